tx_hs_clk_fsm: RTL

//   Transmit-side MIPI D-PHY clock-lane sequencer: drives CLKDp/CLKDn through LP-11 stop,
//   LP-01/LP-00 HS request, HS-0 zero, toggling HS clock, HS trail and exit back to LP-11.

---
 rtl/dphy_pkg.sv | 36 +++
 rtl/dphy_tx_timer.sv | 30 +++
 rtl/tx_hs_clk_fsm.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dphy_pkg.sv
// Shared D-PHY definitions: clock-lane FSM state encoding, line-state constants ({Dp,Dn})
// and counter helpers used by the TX sequencer and the RX monitor FSMs.
package dphy_pkg;

    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] HS0  = 2'b01;
    localparam logic [1:0] HS1  = 2'b10;

    typedef enum logic [3:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_HS_PREP,
        ST_HS_ZERO,
        ST_HS_CLK,
        ST_HS_TRAIL,
        ST_HS_EXIT
`ifdef TX_CLK_ULPS_EN
        ,
        ST_ULPS_RQST,
        ST_ULPS,
        ST_ULPS_EXIT
`endif
    } tx_clk_state_e;

    // A state lasting N cycles is loaded with N-1 and leaves on the edge where it reads zero.
    function automatic cnt_t f_cnt_init(input int unsigned cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/dphy_tx_timer.sv
// 16-bit loadable down-counter for D-PHY state timing; load wins over decrement,
// and the count holds at zero rather than wrapping.
module dphy_tx_timer
    import dphy_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  cnt_t i_load_val,
    input  logic i_dec,
    output cnt_t o_value,
    output logic o_expired
);

    cnt_t r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value   = r_cnt;
    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/tx_hs_clk_fsm.sv
// Transmit-side D-PHY clock-lane sequencer: LP-11 stop, HS request/prepare/zero, HS clock,
// trail and exit. Optional ULPS entry/exit states are built when TX_CLK_ULPS_EN is defined.
module tx_hs_clk_fsm
    import dphy_pkg::*;
#(
    parameter int unsigned T_LPX    = 4,
    parameter int unsigned T_PREP   = 3,
    parameter int unsigned T_ZERO   = 8,
    parameter int unsigned T_POST   = 6,
    parameter int unsigned T_TRAIL  = 5,
    parameter int unsigned T_HSEXIT = 4
`ifdef TX_CLK_ULPS_EN
    ,
    parameter int unsigned T_WAKEUP = 20
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic hs_req,
    input  logic ulps_req,
    output logic CLKDp,
    output logic CLKDn,
    output logic hs_active,
    output logic ulps_active,
    output logic busy
);

    tx_clk_state_e r_state;
    tx_clk_state_e w_next;
    logic          r_dp;
    logic          r_dn;
    logic          r_hs_active;
    logic          r_ulps_active;
    logic          r_busy;

    logic          w_load;
    cnt_t          w_load_val;
    logic          w_dec;
    logic          w_expired;
    cnt_t          w_unused_cnt_value;
    logic [1:0]    w_line;
    logic          w_hs_active;
    logic          w_ulps_active;

`ifndef TX_CLK_ULPS_EN
    logic w_unused_ulps_req;
    assign w_unused_ulps_req = ulps_req;
`endif

    dphy_tx_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_value    (w_unused_cnt_value),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            ST_STOP: begin
                if (hs_req) begin
                    w_next = ST_HS_RQST;
                end
`ifdef TX_CLK_ULPS_EN
                else if (ulps_req) begin
                    w_next = ST_ULPS_RQST;
                end
`endif
            end
            ST_HS_RQST: begin
                w_dec = 1'b1;
                if (w_expired) w_next = ST_HS_PREP;
            end
            ST_HS_PREP: begin
                w_dec = 1'b1;
                if (w_expired) w_next = ST_HS_ZERO;
            end
            ST_HS_ZERO: begin
                w_dec = 1'b1;
                if (w_expired) w_next = ST_HS_CLK;
            end
            // Post window restarts while hs_req is held; leave only after a high half-cycle.
            ST_HS_CLK: begin
                if (hs_req) begin
                    w_load     = 1'b1;
                    w_load_val = f_cnt_init(T_POST);
                end else if (w_expired && r_dp) begin
                    w_next = ST_HS_TRAIL;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_HS_TRAIL: begin
                w_dec = 1'b1;
                if (w_expired) w_next = ST_HS_EXIT;
            end
            ST_HS_EXIT: begin
                w_dec = 1'b1;
                if (w_expired) w_next = ST_STOP;
            end
`ifdef TX_CLK_ULPS_EN
            ST_ULPS_RQST: begin
                w_dec = 1'b1;
                if (w_expired) w_next = ST_ULPS;
            end
            ST_ULPS: begin
                if (!ulps_req) w_next = ST_ULPS_EXIT;
            end
            ST_ULPS_EXIT: begin
                w_dec = 1'b1;
                if (w_expired) w_next = ST_STOP;
            end
`endif
            default: w_next = ST_STOP;
        endcase

        if (w_next != r_state) begin
            w_load = 1'b1;
            case (w_next)
                ST_HS_RQST:   w_load_val = f_cnt_init(T_LPX);
                ST_HS_PREP:   w_load_val = f_cnt_init(T_PREP);
                ST_HS_ZERO:   w_load_val = f_cnt_init(T_ZERO);
                ST_HS_CLK:    w_load_val = f_cnt_init(T_POST);
                ST_HS_TRAIL:  w_load_val = f_cnt_init(T_TRAIL);
                ST_HS_EXIT:   w_load_val = f_cnt_init(T_HSEXIT);
`ifdef TX_CLK_ULPS_EN
                ST_ULPS_RQST: w_load_val = f_cnt_init(T_LPX);
                ST_ULPS_EXIT: w_load_val = f_cnt_init(T_WAKEUP);
`endif
                default:      w_load_val = '0;
            endcase
        end
    end

    // Line state is decoded from the next state so it is registered alongside it.
    always_comb begin
        w_line        = LP11;
        w_hs_active   = 1'b0;
        w_ulps_active = 1'b0;
        case (w_next)
            ST_STOP:      w_line = LP11;
            ST_HS_RQST:   w_line = LP01;
            ST_HS_PREP:   w_line = LP00;
            ST_HS_ZERO:   w_line = HS0;
            ST_HS_CLK: begin
                w_hs_active = 1'b1;
                w_line      = (r_state == ST_HS_CLK) ? {~r_dp, r_dp} : HS1;
            end
            ST_HS_TRAIL:  w_line = HS0;
            ST_HS_EXIT:   w_line = LP11;
`ifdef TX_CLK_ULPS_EN
            ST_ULPS_RQST: w_line = LP10;
            ST_ULPS: begin
                w_line        = LP00;
                w_ulps_active = 1'b1;
            end
            ST_ULPS_EXIT: w_line = LP10;
`endif
            default:      w_line = LP11;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_STOP;
            r_dp          <= 1'b1;
            r_dn          <= 1'b1;
            r_hs_active   <= 1'b0;
            r_ulps_active <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_dp          <= w_line[1];
            r_dn          <= w_line[0];
            r_hs_active   <= w_hs_active;
            r_ulps_active <= w_ulps_active;
            r_busy        <= (w_next != ST_STOP);
        end
    end

    assign CLKDp       = r_dp;
    assign CLKDn       = r_dn;
    assign hs_active   = r_hs_active;
    assign ulps_active = r_ulps_active;
    assign busy        = r_busy;

endmodule
